stream_to_bram: RTL and testbench

- Capture engine: accepts a 32-bit AXI stream and writes it word-by-word into a block RAM through a native BRAM port.
- The captured buffer is read back by software or replayed by the BRAM-to-stream playback block.
- Capture is either immediate or aligned to the fast-command orbit sync.
- Capture length is programmable, and control is a simple start/abort/done interface driven by the parameter-decode wrapper.

---
 rtl/stream_to_bram.sv | 141 ++++++++++++++
 tb/tb_stream_to_bram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_bram.sv
// Capture engine: writes accepted AXI-stream beats word-by-word into a BRAM port.
// Optional macro STREAM_TO_BRAM_TLAST_EN adds data_stream_TLAST to end a capture early.
module stream_to_bram #(
    parameter  int MEM_DEPTH = 2048,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          sync_mode,
    input  logic [15:0]   capture_len,
    input  logic          fc_orbitSync,
    input  logic [31:0]   data_stream_TDATA,
    input  logic          data_stream_TVALID,
`ifdef STREAM_TO_BRAM_TLAST_EN
    input  logic          data_stream_TLAST,
`endif
    output logic          data_stream_TREADY,
    output logic          bram_CLK,
    output logic          bram_RST,
    output logic          bram_EN,
    output logic [3:0]    bram_WE,
    output logic [31:0]   bram_ADDR,
    output logic [31:0]   bram_DIN,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words_written,
    output logic [15:0]   drop_count,
    output logic [1:0]    dbg_state
);

    // Handshake: a beat transfers on any clk edge where TVALID && TREADY;
    // TREADY is 1 in every state once out of reset, so the block never stalls.
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

    state_t      r_state;
    logic        r_tready;
    logic [AW:0] r_words;
    logic [AW:0] r_len;
    logic [15:0] r_drops;
    logic        r_en;
    logic [3:0]  r_we;
    logic [31:0] r_addr;
    logic [31:0] r_din;

    logic        w_accept;
    logic        w_trig;
    logic        w_write;
    logic        w_drop;
    logic        w_last;
    logic        w_end;
    logic [AW:0] w_words_nx;
    logic [AW:0] w_len_eff;

`ifdef STREAM_TO_BRAM_TLAST_EN
    assign w_last = data_stream_TLAST;
`else
    assign w_last = 1'b0;
`endif

    assign w_accept   = data_stream_TVALID && r_tready;
    assign w_trig     = (r_state == S_ARMED) && (!sync_mode || fc_orbitSync);
    assign w_write    = w_accept && !abort && ((r_state == S_CAPTURE) || w_trig);
    assign w_drop     = w_accept && !abort && !w_write;
    assign w_words_nx = r_words + ONE_W;
    assign w_end      = w_write && ((w_words_nx == r_len) || w_last);
    // Zero or oversize lengths fall back to the full buffer.
    assign w_len_eff  = ((capture_len == 16'd0) || ({1'b0, capture_len} > 17'(MEM_DEPTH)))
                        ? DEPTH_W : (AW+1)'(capture_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tready <= 1'b0;
            r_words  <= '0;
            r_len    <= '0;
            r_drops  <= '0;
            r_en     <= 1'b0;
            r_we     <= 4'h0;
            r_addr   <= '0;
            r_din    <= '0;
        end else begin
            r_tready <= 1'b1;
            r_en     <= 1'b0;
            r_we     <= 4'h0;
            if (w_write) begin
                r_en    <= 1'b1;
                r_we    <= 4'hF;
                r_addr  <= {{(30-AW){1'b0}}, r_words[AW-1:0], 2'b00};
                r_din   <= data_stream_TDATA;
                r_words <= w_words_nx;
            end
            if (w_drop && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state <= S_ARMED;
                            r_words <= '0;
                            r_drops <= '0;
                            r_len   <= w_len_eff;
                        end
                    end
                    S_ARMED: begin
                        if (w_trig) begin
                            r_state <= w_end ? S_DONE : S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_end) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_stream_TREADY = r_tready;
    assign bram_CLK           = clk;
    assign bram_RST           = reset;
    assign bram_EN            = r_en;
    assign bram_WE            = r_we;
    assign bram_ADDR          = r_addr;
    assign bram_DIN           = r_din;
    assign busy               = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign done               = (r_state == S_DONE);
    assign words_written      = r_words;
    assign drop_count         = r_drops;
    assign dbg_state          = r_state;

endmodule

// File: tb/tb_stream_to_bram.sv
// Directed bench for stream_to_bram (MEM_DEPTH=16): length table plus corner-case sequences.
module tb_stream_to_bram;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort, sync_mode, fc_orbitSync;
    logic [15:0]   capture_len;
    logic [31:0]   tdata;
    logic          tvalid, tlast;
    logic          tready, bram_clk, bram_rst, bram_en;
    logic [3:0]    bram_we;
    logic [31:0]   bram_addr, bram_din;
    logic          busy, done;
    logic [AW:0]   words_written;
    logic [15:0]   drop_count;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    stream_to_bram #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sync_mode(sync_mode), .capture_len(capture_len), .fc_orbitSync(fc_orbitSync),
        .data_stream_TDATA(tdata), .data_stream_TVALID(tvalid),
`ifdef STREAM_TO_BRAM_TLAST_EN
        .data_stream_TLAST(tlast),
`endif
        .data_stream_TREADY(tready), .bram_CLK(bram_clk), .bram_RST(bram_rst),
        .bram_EN(bram_en), .bram_WE(bram_we), .bram_ADDR(bram_addr), .bram_DIN(bram_din),
        .busy(busy), .done(done), .words_written(words_written),
        .drop_count(drop_count), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every BRAM write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && bram_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bram_addr, bram_din);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bram_addr, bram_din} !== e || bram_we !== 4'hF) begin
                    n_err++;
                    $display("FAIL write: addr 0x%0h data 0x%0h we %h, expected addr 0x%0h data 0x%0h we f",
                             bram_addr, bram_din, bram_we, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic sm);
        capture_len = len;
        sync_mode   = sm;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic exp_w, input int word, input logic last);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        if (exp_w) exp_q.push_back({32'(word * 4), d});
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    typedef struct {
        logic [15:0] len;
        int          exp_l;
        logic [31:0] base;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'd4,   4,  32'hA0};
        vecs[1] = '{16'd1,   1,  32'h100};
        vecs[2] = '{16'd2,   2,  32'h200};
        vecs[3] = '{16'd15,  15, 32'h300};
        vecs[4] = '{16'd16,  16, 32'h400};
        vecs[5] = '{16'd17,  16, 32'h500};
        vecs[6] = '{16'd0,   16, 32'h600};
        vecs[7] = '{16'd100, 16, 32'h700};

        reset = 1'b1; start = 0; abort = 0; sync_mode = 0; fc_orbitSync = 0;
        capture_len = 0; tdata = 0; tvalid = 0; tlast = 0;
        #3;
        chk("rst_tready", 32'(tready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_words", 32'(words_written), 0);
        chk("rst_drops", 32'(drop_count), 0);
        chk("rst_en", 32'(bram_en), 0);
        chk("rst_addr", bram_addr, 0);
        tick();
        reset = 1'b0;
        chk("tready_before_edge", 32'(tready), 0);
        tick();
        chk("tready_after_edge", 32'(tready), 1);
        chk("state_idle", 32'(dbg_state), 0);

        // Beats in IDLE are dropped and counted.
        beat(32'h11, 0, 0, 0);
        beat(32'h12, 0, 0, 0);
        chk("idle_drops", 32'(drop_count), 2);

        // Length table: L beats written, one extra beat dropped in DONE.
        for (int v = 0; v < 8; v++) begin
            do_start(vecs[v].len, 1'b0);
            chk($sformatf("v%0d_busy", v), 32'(busy), 1);
            chk($sformatf("v%0d_drops_clr", v), 32'(drop_count), 0);
            for (int i = 0; i <= vecs[v].exp_l; i++)
                beat(vecs[v].base + 32'(i), i < vecs[v].exp_l, i, 0);
            chk($sformatf("v%0d_done", v), 32'(done), 1);
            chk($sformatf("v%0d_words", v), 32'(words_written), 32'(vecs[v].exp_l));
            chk($sformatf("v%0d_drops", v), 32'(drop_count), 1);
        end

        // Orbit-synchronous trigger: six dropped beats, then B6 coincident with sync.
        do_start(16'd3, 1'b1);
        for (int i = 0; i < 6; i++) beat(32'hB0 + 32'(i), 0, 0, 0);
        chk("sync_armed", 32'(dbg_state), 1);
        chk("sync_drops", 32'(drop_count), 6);
        fc_orbitSync = 1'b1;
        beat(32'hB6, 1, 0, 0);
        fc_orbitSync = 1'b0;
        chk("sync_capture", 32'(dbg_state), 2);
        beat(32'hB7, 1, 1, 0);
        beat(32'hB8, 1, 2, 0);
        chk("sync_done", 32'(done), 1);
        chk("sync_words", 32'(words_written), 3);

        // Gapped stream: no write in the cycles after an idle TVALID.
        do_start(16'd2, 1'b0);
        beat(32'hC0, 1, 0, 0);
        chk("gap_en_on", 32'(bram_en), 1);
        tick();
        chk("gap_en_off", 32'(bram_en), 0);
        chk("gap_we_off", 32'(bram_we), 0);
        chk("gap_addr_hold", bram_addr, 0);
        tick();
        beat(32'hC1, 1, 1, 0);
        chk("gap_done", 32'(done), 1);
        chk("gap_words", 32'(words_written), 2);

        // Length latched at start: later capture_len changes are ignored.
        do_start(16'd2, 1'b0);
        capture_len = 16'd5;
        beat(32'hE0, 1, 0, 0);
        beat(32'hE1, 1, 1, 0);
        beat(32'hE2, 0, 0, 0);
        chk("latch_words", 32'(words_written), 2);
        chk("latch_done", 32'(done), 1);

        // Abort mid-capture keeps words_written; abort beats start when both pulse.
        do_start(16'd8, 1'b0);
        beat(32'hF0, 1, 0, 0);
        beat(32'hF1, 1, 1, 0);
        beat(32'hF2, 1, 2, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(dbg_state), 0);
        chk("abort_words", 32'(words_written), 3);
        do_start(16'd4, 1'b1);
        chk("armed_again", 32'(dbg_state), 1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_wins_state", 32'(dbg_state), 0);
        chk("abort_wins_busy", 32'(busy), 0);

`ifdef STREAM_TO_BRAM_TLAST_EN
        do_start(16'd8, 1'b0);
        beat(32'hD0, 1, 0, 0);
        beat(32'hD1, 1, 1, 0);
        beat(32'hD2, 1, 2, 1);
        chk("tlast_done", 32'(done), 1);
        chk("tlast_words", 32'(words_written), 3);
`endif

        // Asynchronous reset after 5 of 10 words.
        do_start(16'd10, 1'b0);
        for (int i = 0; i < 5; i++) beat(32'h900 + 32'(i), 1, i, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(dbg_state), 0);
        chk("mid_rst_tready", 32'(tready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_words", 32'(words_written), 0);
        chk("mid_rst_en", 32'(bram_en), 0);
        chk("mid_rst_addr", bram_addr, 0);
        chk("mid_rst_din", bram_din, 0);
        tick();
        reset = 1'b0;
        chk("mid_rst_tready_hold", 32'(tready), 0);
        tick();
        chk("mid_rst_tready_up", 32'(tready), 1);
        chk("mid_rst_idle", 32'(dbg_state), 0);

        tick();
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
